maze_rat_solver: RTL and testbench

//  Parametrised successor of the rat maze controller. Performs a depth-first search over a
//  2^COORD_W x 2^COORD_W maze held in external 1-bit cell memory, from a runtime start to a

---
 rtl/maze_pkg.sv | 46 ++++
 rtl/dir_stack.sv | 43 ++++
 rtl/maze_rat_solver.sv | 254 +++++++++++++++++++++++++
 tb/tb_maze_rat_solver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze rat solver: direction/state encodings and
// neighbour arithmetic with off-grid detection.
package maze_pkg;

  localparam int MAX_CW = 16;
  typedef logic [MAX_CW-1:0] coord_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PROBE, S_CHECK, S_ADVANCE, S_BACKTRACK, S_DONE, S_FAIL, S_REPLAY
  } state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   off;
  } nbr_t;

  // The encoding pairs opposite directions as bitwise complements (0<->3, 1<->2).
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

  function automatic nbr_t step(input coord_t x, input coord_t y, input dir_t d,
                                input coord_t max_c);
    nbr_t n;
    n.x   = x;
    n.y   = y;
    n.off = 1'b0;
    case (d)
      UP:    begin n.off = (y == '0);    n.y = y - coord_t'(1); end
      RIGHT: begin n.off = (x == max_c); n.x = x + coord_t'(1); end
      LEFT:  begin n.off = (x == '0);    n.x = x - coord_t'(1); end
      DOWN:  begin n.off = (y == max_c); n.y = y + coord_t'(1); end
      default: n.off = 1'b1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dir_stack.sv
// LIFO of move directions with an indexed read port used to replay the path
// bottom-to-top.
module dir_stack #(
  parameter  int DEPTH = 64,
  parameter  int W     = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int SPW   = AW + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [W-1:0]   data_i,
  input  logic [AW-1:0]  rd_idx_i,
  output logic [SPW-1:0] sp_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [W-1:0]   top_o,
  output logic [W-1:0]   rd_data_o
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [SPW-1:0] sp_q;

  // NOTE: storage is not reset; only entries below sp are ever read as valid data.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[sp_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) sp_q <= '0;
    else if (push_i)    sp_q <= sp_q + SPW'(1);
    else if (pop_i)     sp_q <= sp_q - SPW'(1);
  end

  assign sp_o      = sp_q;
  assign full_o    = (sp_q == SPW'(DEPTH));
  assign empty_o   = (sp_q == '0);
  assign top_o     = mem_q[sp_q[AW-1:0] - AW'(1)];
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/maze_rat_solver.sv
// Depth-first maze search over external 1-bit cell memory, with path replay from
// an internal direction stack.
module maze_rat_solver
  import maze_pkg::*;
#(
  parameter int COORD_W     = 4,
  parameter int STACK_DEPTH = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Run,
  input  logic [COORD_W-1:0] StartX,
  input  logic [COORD_W-1:0] StartY,
  input  logic [COORD_W-1:0] GoalX,
  input  logic [COORD_W-1:0] GoalY,
  input  logic               Dout,
  output logic               RD,
  output logic               WR,
  output logic               Din,
  output logic [COORD_W-1:0] MemX,
  output logic [COORD_W-1:0] MemY,
  output logic [COORD_W-1:0] PosX,
  output logic [COORD_W-1:0] PosY,
  output logic [1:0]         Move,
  output logic               MoveValid,
  output logic               Done,
  output logic               Fail,
  output logic               Overflow
);

  localparam int     AW    = $clog2(STACK_DEPTH);
  localparam int     SPW   = AW + 1;
  localparam coord_t MAX_C = coord_t'((1 << COORD_W) - 1);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] start_x_q, start_x_d, start_y_q, start_y_d;
  logic [COORD_W-1:0] goal_x_q, goal_x_d, goal_y_q, goal_y_d;
  dir_t               dir_q, dir_d;
  logic [SPW-1:0]     idx_q, idx_d;
  logic               done_q, done_d, fail_q, fail_d, ovf_q, ovf_d;

  logic               stk_clr, stk_push, stk_pop, stk_full, stk_empty;
  logic [SPW-1:0]     stk_sp;
  logic [1:0]         stk_top, stk_rd;

  logic               rd, wr, move_valid;
  logic [COORD_W-1:0] mem_x, mem_y;
  dir_t               move, back_dir;

  nbr_t               nbr, back, rep;
  logic [COORD_W-1:0] nbr_x, nbr_y, back_x, back_y, rep_x, rep_y;
  logic               unused_hi;

  dir_stack #(.DEPTH(STACK_DEPTH), .W(2)) u_stack (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clr_i     (stk_clr),
    .push_i    (stk_push),
    .pop_i     (stk_pop),
    .data_i    (dir_q),
    .rd_idx_i  (idx_q[AW-1:0]),
    .sp_o      (stk_sp),
    .full_o    (stk_full),
    .empty_o   (stk_empty),
    .top_o     (stk_top),
    .rd_data_o (stk_rd)
  );

  // Three neighbour views: forward probe, backtrack step, replay step.
  assign back_dir = opposite(dir_t'(stk_top));
  assign nbr  = step(coord_t'(pos_x_q), coord_t'(pos_y_q), dir_q, MAX_C);
  assign back = step(coord_t'(pos_x_q), coord_t'(pos_y_q), back_dir, MAX_C);
  assign rep  = step(coord_t'(pos_x_q), coord_t'(pos_y_q), dir_t'(stk_rd), MAX_C);
  assign nbr_x  = nbr.x[COORD_W-1:0];
  assign nbr_y  = nbr.y[COORD_W-1:0];
  assign back_x = back.x[COORD_W-1:0];
  assign back_y = back.y[COORD_W-1:0];
  assign rep_x  = rep.x[COORD_W-1:0];
  assign rep_y  = rep.y[COORD_W-1:0];
  assign unused_hi = ^{nbr, back, rep};

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    goal_x_d  = goal_x_q;
    goal_y_d  = goal_y_q;
    dir_d     = dir_q;
    idx_d     = idx_q;
    done_d    = done_q;
    fail_d    = fail_q;
    ovf_d     = ovf_q;
    stk_clr   = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    mem_x     = '0;
    mem_y     = '0;
    move      = UP;
    move_valid = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (Start) begin
          start_x_d = StartX;
          start_y_d = StartY;
          goal_x_d  = GoalX;
          goal_y_d  = GoalY;
          pos_x_d   = StartX;
          pos_y_d   = StartY;
          dir_d     = UP;
          stk_clr   = 1'b1;
          done_d    = 1'b0;
          fail_d    = 1'b0;
          ovf_d     = 1'b0;
          state_d   = S_INIT;
        end else if (state_q == S_DONE && Run) begin
          pos_x_d = start_x_q;
          pos_y_d = start_y_q;
          idx_d   = '0;
          state_d = S_REPLAY;
        end
      end
      S_INIT: begin
        wr    = 1'b1;
        mem_x = start_x_q;
        mem_y = start_y_q;
        if (start_x_q == goal_x_q && start_y_q == goal_y_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        rd      = !nbr.off;
        mem_x   = nbr_x;
        mem_y   = nbr_y;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (nbr.off || Dout) begin
          if (dir_q != DOWN) begin
            dir_d   = dir_t'(dir_q + 2'd1);
            state_d = S_PROBE;
          end else begin
            state_d = S_BACKTRACK;
          end
        end else if (stk_full) begin
          fail_d  = 1'b1;
          ovf_d   = 1'b1;
          state_d = S_FAIL;
        end else begin
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        stk_push = 1'b1;
        pos_x_d  = nbr_x;
        pos_y_d  = nbr_y;
        wr       = 1'b1;
        mem_x    = nbr_x;
        mem_y    = nbr_y;
        move     = dir_q;
        if (nbr_x == goal_x_q && nbr_y == goal_y_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          dir_d   = UP;
          state_d = S_PROBE;
        end
      end
      S_BACKTRACK: begin
        if (stk_empty) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          stk_pop = 1'b1;
          pos_x_d = back_x;
          pos_y_d = back_y;
          move    = back_dir;
          if (dir_t'(stk_top) != DOWN) begin
            dir_d   = dir_t'(stk_top + 2'd1);
            state_d = S_PROBE;
          end
        end
      end
      S_REPLAY: begin
        if (idx_q == stk_sp) begin
          state_d = S_DONE;
        end else begin
          move_valid = 1'b1;
          move       = dir_t'(stk_rd);
          pos_x_d    = rep_x;
          pos_y_d    = rep_y;
          idx_d      = idx_q + SPW'(1);
          if (idx_d == stk_sp) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      start_x_q <= '0;
      start_y_q <= '0;
      goal_x_q  <= '0;
      goal_y_q  <= '0;
      dir_q     <= UP;
      idx_q     <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      start_x_q <= start_x_d;
      start_y_q <= start_y_d;
      goal_x_q  <= goal_x_d;
      goal_y_q  <= goal_y_d;
      dir_q     <= dir_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      ovf_q     <= ovf_d;
    end
  end

  assign RD        = rd;
  assign WR        = wr;
  assign Din       = wr;
  assign MemX      = mem_x;
  assign MemY      = mem_y;
  assign PosX      = pos_x_q;
  assign PosY      = pos_y_q;
  assign Move      = move;
  assign MoveValid = move_valid;
  assign Done      = done_q;
  assign Fail      = fail_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_maze_rat_solver.sv
// Directed bench for maze_rat_solver on a 4x4 grid with a 4-deep stack; a behavioural
// cell memory and a move scoreboard checked on every position change.
module tb_maze_rat_solver;

  localparam int CW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, start_p, run_p, dout;
  logic [CW-1:0] sx, sy, gx, gy;
  logic          rd, wr, din, move_valid, done, fail, ovf;
  logic [CW-1:0] mem_x, mem_y, pos_x, pos_y;
  logic [1:0]    move;

  always #5 clk = ~clk;

  maze_rat_solver #(.COORD_W(CW), .STACK_DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .Start(start_p), .Run(run_p),
    .StartX(sx), .StartY(sy), .GoalX(gx), .GoalY(gy), .Dout(dout),
    .RD(rd), .WR(wr), .Din(din), .MemX(mem_x), .MemY(mem_y),
    .PosX(pos_x), .PosY(pos_y), .Move(move), .MoveValid(move_valid),
    .Done(done), .Fail(fail), .Overflow(ovf)
  );

  typedef struct packed {
    logic [1:0]    dir;
    logic          mv;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } step_t;

  step_t         exp_q[$];
  logic [15:0]   maze;             // bit y*4+x: 1 = wall or visited
  int            checks = 0, errors = 0, wr_cnt = 0, strobe_bad = 0;
  logic          mon_en = 1'b0, prev_mv = 1'b0;
  logic [CW-1:0] prev_x = '0, prev_y = '0;
  logic [1:0]    prev_move = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {rd, wr, din, mem_x, mem_y, pos_x, pos_y, move, move_valid, done, fail, ovf};
  endfunction

  task automatic expect_step(input logic [1:0] d, input logic mv, input int x, input int y);
    step_t e;
    e.dir = d;
    e.mv  = mv;
    e.x   = CW'(x);
    e.y   = CW'(y);
    exp_q.push_back(e);
  endtask

  // One clock: memory model acts on the strobes, then every position change is
  // matched against the next expected step.
  task automatic tick();
    step_t e;
    @(negedge clk);
    if (rd) dout = maze[{mem_y, mem_x}];
    if (wr) begin
      maze[{mem_y, mem_x}] = 1'b1;
      wr_cnt++;
    end
    if ((rd && wr) || (wr && !din)) strobe_bad++;
    if (mon_en && (pos_x != prev_x || pos_y != prev_y)) begin
      check("step_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("step_dir", 32'(prev_move), 32'(e.dir));
        check("step_valid", 32'(prev_mv), 32'(e.mv));
        check("step_pos", 32'({pos_x, pos_y}), 32'({e.x, e.y}));
      end
    end
    prev_x    = pos_x;
    prev_y    = pos_y;
    prev_move = move;
    prev_mv   = move_valid;
  endtask

  task automatic load_maze(input logic [15:0] walls);
    maze = walls;
    dout = 1'b0;
  endtask

  task automatic pulse_start(input int ax, input int ay, input int bx, input int by);
    mon_en  = 1'b0;
    sx      = CW'(ax);
    sy      = CW'(ay);
    gx      = CW'(bx);
    gy      = CW'(by);
    start_p = 1'b1;
    tick();
    start_p = 1'b0;
    mon_en  = 1'b1;
  endtask

  task automatic pulse_run();
    mon_en = 1'b0;
    run_p  = 1'b1;
    tick();
    run_p  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_to_end(input string tag, input int budget);
    int n = 0;
    while (!(done || fail) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_p = 1'b0; run_p = 1'b0;
    sx = '0; sy = '0; gx = '0; gy = '0;
    load_maze(16'hFFFF);
    repeat (3) tick();
    check("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_outputs", 32'(outs()), 32'd0);

    // Open row Y=0, three moves right.
    load_maze(16'hFFF0);
    expect_step(2'd1, 1'b0, 1, 0);
    expect_step(2'd1, 1'b0, 2, 0);
    expect_step(2'd1, 1'b0, 3, 0);
    pulse_start(0, 0, 3, 0);
    run_to_end("t1_budget", 200);
    check("t1_done", 32'(done), 32'd1);
    check("t1_fail", 32'(fail), 32'd0);
    check("t1_ovf", 32'(ovf), 32'd0);
    check("t1_pos", 32'({pos_x, pos_y}), 32'({2'd3, 2'd0}));

    // Replay of the row path: three valid steps, back in DONE at the goal.
    expect_step(2'd1, 1'b1, 1, 0);
    expect_step(2'd1, 1'b1, 2, 0);
    expect_step(2'd1, 1'b1, 3, 0);
    pulse_run();
    repeat (5) tick();
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_pos", 32'({pos_x, pos_y}), 32'({2'd3, 2'd0}));
    check("t5_mv_idle", 32'(move_valid), 32'd0);
    check("t5_done", 32'(done), 32'd1);

    // Upward dead end of two cells, backtrack, then right to the goal.
    load_maze(16'hF1DD);
    expect_step(2'd0, 1'b0, 1, 1);
    expect_step(2'd0, 1'b0, 1, 0);
    expect_step(2'd3, 1'b0, 1, 1);
    expect_step(2'd3, 1'b0, 1, 2);
    expect_step(2'd1, 1'b0, 2, 2);
    expect_step(2'd1, 1'b0, 3, 2);
    pulse_start(1, 2, 3, 2);
    run_to_end("t2_budget", 300);
    check("t2_done", 32'(done), 32'd1);
    check("t2_pos", 32'({pos_x, pos_y}), 32'({2'd3, 2'd2}));
    expect_step(2'd1, 1'b1, 2, 2);
    expect_step(2'd1, 1'b1, 3, 2);
    pulse_run();
    repeat (4) tick();
    check("t2_replay_drained", 32'(exp_q.size()), 32'd0);
    check("t2_replay_pos", 32'({pos_x, pos_y}), 32'({2'd3, 2'd2}));

    // Goal unreachable: backtrack to an empty stack.
    load_maze(16'hFFFC);
    expect_step(2'd1, 1'b0, 1, 0);
    expect_step(2'd2, 1'b0, 0, 0);
    pulse_start(0, 0, 3, 3);
    run_to_end("t3_budget", 300);
    check("t3_fail", 32'(fail), 32'd1);
    check("t3_ovf", 32'(ovf), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    check("t3_pos", 32'({pos_x, pos_y}), 32'({2'd0, 2'd0}));
    pulse_run();
    repeat (2) tick();
    check("t3_run_ignored", 32'({pos_x, pos_y, move_valid, fail}), 32'({2'd0, 2'd0, 1'b0, 1'b1}));

    // Six-cell corridor overflows the 4-deep stack on the fifth open neighbour.
    load_maze(16'hF770);
    expect_step(2'd1, 1'b0, 1, 0);
    expect_step(2'd1, 1'b0, 2, 0);
    expect_step(2'd1, 1'b0, 3, 0);
    expect_step(2'd3, 1'b0, 3, 1);
    pulse_start(0, 0, 0, 3);
    run_to_end("t4_budget", 300);
    check("t4_fail", 32'(fail), 32'd1);
    check("t4_ovf", 32'(ovf), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    check("t4_pos", 32'({pos_x, pos_y}), 32'({2'd3, 2'd1}));

    // Reset in the middle of a probe, then a search whose start is its goal.
    load_maze(16'hFFF0);
    pulse_start(0, 0, 3, 0);
    tick();
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    check("t6_reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_idle_outputs", 32'(outs()), 32'd0);
    wr_cnt = 0;
    pulse_start(2, 1, 2, 1);
    tick();
    check("t6_done_after_init", 32'(done), 32'd1);
    check("t6_single_wr", 32'(wr_cnt), 32'd1);
    check("t6_pos", 32'({pos_x, pos_y}), 32'({2'd2, 2'd1}));
    pulse_run();
    repeat (3) tick();
    check("t6_empty_replay", 32'({pos_x, pos_y, move_valid, done}), 32'({2'd2, 2'd1, 1'b0, 1'b1}));
    check("t6_wr_total", 32'(wr_cnt), 32'd1);

    check("strobe_exclusive", 32'(strobe_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
